// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with an internal HI/LO pair.
// Handles MULT/MULTU (iterative shift-add) and DIV/DIVU (restoring divider)
// plus single-cycle MTHI/MTLO moves. Signed operations run on magnitudes and
// the result signs are applied in the FIX state.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   defined   -> MULT/MULTU complete in one cycle through a combinational
//                multiplier; busy is never raised for multiplies.
//   undefined -> multiplies use the iterative RUN/FIX path like divides.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   request, sampled only while busy=0
//   op     in   0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   a      in   rs operand (multiplicand / dividend / move source)
//   b      in   rt operand (multiplier / divisor)
//   flush  in   abort any in-flight or newly requested operation
//   busy   out  unit occupied, starts ignored
//   done   out  one-cycle pulse after HI/LO were written
//   hi     out  HI register
//   lo     out  LO register
//
// FSM states:
//   state  | meaning
//   IDLE   | waiting for start; MTHI/MTLO (and fast multiplies) finish here
//   RUN    | one multiply/divide bit per cycle, counter WIDTH-1 down to 0
//   FIX    | apply result signs, write HI/LO, pulse done

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
  logic             is_div_q, neg_res_q, neg_rem_q, div_zero_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_abs_q;
  // acc_q: product upper half / partial remainder
  // sh_q : multiplier being consumed / dividend shifting into quotient
  logic [WIDTH-1:0] acc_q, sh_q;

  // Request decode
  logic             accept, is_mul_op, is_div_op, is_mt_op, signed_op;
  logic             iter_start, fast_wr;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign accept    = (state_q == S_IDLE) && start && !flush;
  assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_mt_op  = (op == OP_MTHI) || (op == OP_MTLO);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_abs     = a_neg ? -a : a;
  assign b_abs     = b_neg ? -b : b;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod, fast_fix;
  assign iter_start = accept && is_div_op;
  assign fast_wr    = accept && is_mul_op;
  assign fast_prod  = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
  assign fast_fix   = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
`else
  assign iter_start = accept && (is_mul_op || is_div_op);
  assign fast_wr    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (iter_start) state_d = S_RUN;
        S_RUN:   if (cnt_q == '0) state_d = S_FIX;
        S_FIX:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs
  logic iter_en, fix_wr, mt_wr;
  always_comb begin
    busy    = (state_q != S_IDLE);
    iter_en = (state_q == S_RUN);
    fix_wr  = (state_q == S_FIX) && !flush;
    mt_wr   = accept && is_mt_op;
  end

  // One iteration step for either operation
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] acc_d, sh_d;
  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, (sh_q[0] ? b_abs_q : {WIDTH{1'b0}})};
    div_shift = {acc_q, sh_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_abs_q};
    // Partial remainder stays below the divisor, so the top bit of the
    // difference is a clean borrow flag.
    div_ge    = ~div_diff[WIDTH];
    if (is_div_q) begin
      acc_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      sh_d  = {sh_q[WIDTH-2:0], div_ge};
    end else begin
      acc_d = mul_sum[WIDTH:1];
      sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end
  end

  // Final sign correction
  logic [2*WIDTH-1:0] mul_prod, mul_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  always_comb begin
    mul_prod = {acc_q, sh_q};
    mul_fix  = neg_res_q ? -mul_prod : mul_prod;
    fix_hi   = mul_fix[2*WIDTH-1:WIDTH];
    fix_lo   = mul_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        fix_hi = a_q;
        fix_lo = {WIDTH{1'b1}};
      end else begin
        fix_hi = neg_rem_q ? -acc_q : acc_q;
        fix_lo = neg_res_q ? -sh_q : sh_q;
      end
    end
  end

  // Datapath and HI/LO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      a_q        <= '0;
      b_abs_q    <= '0;
      acc_q      <= '0;
      sh_q       <= '0;
    end else begin
      done_q <= 1'b0;
      if (iter_start) begin
        cnt_q      <= CNT_W'(WIDTH-1);
        acc_q      <= '0;
        sh_q       <= a_abs;
        b_abs_q    <= b_abs;
        a_q        <= a;
        is_div_q   <= is_div_op;
        neg_res_q  <= a_neg ^ b_neg;
        neg_rem_q  <= a_neg;
        div_zero_q <= (b == '0);
      end else if (iter_en) begin
        if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        acc_q <= acc_d;
        sh_q  <= sh_d;
      end
      if (fix_wr) begin
        hi_q   <= fix_hi;
        lo_q   <= fix_lo;
        done_q <= 1'b1;
      end
      if (mt_wr) begin
        if (op == OP_MTHI) hi_q <= a;
        else               lo_q <= a;
        done_q <= 1'b1;
      end
`ifdef MULDIV_FAST_MUL_EN
      if (fast_wr) begin
        hi_q   <= fast_fix[2*WIDTH-1:WIDTH];
        lo_q   <= fast_fix[WIDTH-1:0];
        done_q <= 1'b1;
      end
`endif
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (WIDTH=32): scoreboard of expected {hi,lo}
// pushed at issue time and popped whenever done pulses.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int ITER_LAT = W + 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = ITER_LAT;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] sb_q[$];
  logic [W-1:0] m_hi, m_lo;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference using native arithmetic
  function automatic logic [63:0] mdl(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int sq, sr;
    case (o)
      3'd1: return longint'($signed(x)) * longint'($signed(y));
      3'd2: return {32'd0, x} * {32'd0, y};
      3'd3: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      3'd4: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return {m_hi, m_lo};
    endcase
  endfunction

  // Scoreboard consumer
  initial begin : sb_mon
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        check("sb_pending", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) check("sb_result", {hi, lo}, sb_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 3'd0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    if (exp_lat > 0) check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_busy_off"}, 64'(busy), 64'd0);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic [63:0] exp, input int lat);
    sb_q.push_back(exp);
    issue(o, x, y);
    wait_done(tag, lat);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  initial begin
    int dn;
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) tick();
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();

    // Multiply and divide corner values
    run("mult",   3'd1, 32'hFFFF_FFFF, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFFB}, MUL_LAT);
    run("multu",  3'd2, 32'hFFFF_FFFF, 32'd5, {32'h0000_0004, 32'hFFFF_FFFB}, MUL_LAT);
    run("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, ITER_LAT);
    run("divu",   3'd4, 32'd7, 32'd2, {32'd1, 32'd3}, ITER_LAT);
    run("div_z",  3'd3, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, ITER_LAT);
    run("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, ITER_LAT);

    // Moves, then aborted DIVU with an ignored start in between
    run("mthi", 3'd5, 32'hAAAA_0000, 32'd0, {32'hAAAA_0000, m_lo}, 0);
    run("mtlo", 3'd6, 32'h0000_5555, 32'd0, {32'hAAAA_0000, 32'h0000_5555}, 0);
    issue(3'd4, 32'd100, 32'd3);
    repeat (4) tick();
    issue(3'd5, 32'h1234_5678, 32'd0);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy", 64'(busy), 64'd0);
    check("fl_done", 64'(done), 64'd0);
    check("fl_hi", 64'(hi), 64'hAAAA_0000);
    check("fl_lo", 64'(lo), 64'h0000_5555);
    dn = 0;
    repeat (40) begin
      tick();
      if (done) dn++;
    end
    check("fl_no_done", 64'(dn), 64'd0);

    // Flush and start together: start dropped
    start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; flush = 1'b1;
    tick();
    start = 1'b0; op = 3'd0; flush = 1'b0;
    check("flst_done", 64'(done), 64'd0);
    tick();
    check("flst_hi", 64'(hi), 64'hAAAA_0000);

    // Reset in the middle of a MULTU
    issue(3'd2, 32'h1357_9BDF, 32'h2468_ACE0);
    repeat (18) tick();
    rst_n = 1'b0;
    tick();
    check("mrst_hi", 64'(hi), 64'd0);
    check("mrst_lo", 64'(lo), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    run("mtlo7", 3'd6, 32'd7, 32'd0, {32'd0, 32'd7}, 0);

    // MTHI issued in the done cycle of a DIVU
    run("divu92", 3'd4, 32'd9, 32'd2, {32'd1, 32'd4}, ITER_LAT);
    sb_q.push_back({32'd3, 32'd4});
    start = 1'b1; op = 3'd5; a = 32'd3;
    tick();
    start = 1'b0; op = 3'd0;
    check("b2b_done2", 64'(done), 64'd1);
    check("b2b_hi", 64'(hi), 64'd3);
    check("b2b_lo", 64'(lo), 64'd4);
    tick();
    check("b2b_done_clr", 64'(done), 64'd0);
    m_hi = 32'd3; m_lo = 32'd4;

    // Random operations against the reference model
    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(1, 4));
      rx = $urandom;
      ry = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (i % 4 == 1) ry = -ry;
      run("rnd", ro, rx, ry, mdl(ro, rx, ry), (ro <= 3'd2) ? MUL_LAT : ITER_LAT);
    end

    repeat (3) tick();
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
